debounce_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-input button debouncer.
- Each channel synchronises an asynchronous noisy input, filters it for stability, and outputs a clean level.
- Each channel also produces one-cycle press and release pulses and an optional auto-repeat pulse train while held (used for Tetris left/right/down key repeat).
- Sits between the board push-buttons and the game controller.

---
 rtl/debounce_multi.sv | 132 +++++++++++++
 tb/tb_debounce_multi.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Per-channel synchronise + stability filter with press/release pulses and auto-repeat.
// Latency: clean level follows a stable input after NDELAY+4 edges; pulses coincide with the level change.
// Backpressure: none; level inputs in, free-running registered pulses out.
module debounce_multi #(
    parameter int NCH           = 4,
    parameter int NDELAY        = 650000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 16000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic           Clk,
    input  logic           RstN,
    input  logic [NCH-1:0] DataNoisy,
    output logic [NCH-1:0] DataClean,
    output logic [NCH-1:0] Rise,
    output logic [NCH-1:0] Fall,
    output logic [NCH-1:0] Repeat,
    output logic [NCH-1:0] KeyEvent
);

    localparam int CW   = $clog2(NDELAY + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(NDELAY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_REP  = 2'd2;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [1:0]    sync_q;
        logic          cand_q;
        logic [CW-1:0] cnt_q;
        logic          clean_q;
        logic          rise_q;
        logic          fall_q;
        logic          rep_q;
        logic          key_q;
        logic          settle;
        logic          rise_set;
        logic          fall_set;
        logic          rep_set;

        // candidate has been stable for NDELAY counted cycles
        assign settle   = (sync_q[1] == cand_q) && (cnt_q == CNT_MAX);
        assign rise_set = settle &  cand_q & ~clean_q;
        assign fall_set = settle & ~cand_q &  clean_q;

        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN) begin
                sync_q  <= 2'b00;
                cand_q  <= 1'b0;
                cnt_q   <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                rep_q   <= 1'b0;
                key_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], DataNoisy[ch]};
                if (sync_q[1] != cand_q) begin
                    cand_q <= sync_q[1];
                    cnt_q  <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    clean_q <= cand_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                rise_q <= rise_set;
                fall_q <= fall_set;
                rep_q  <= rep_set;
                key_q  <= rise_set | rep_set;
            end
        end

        if (REPEAT_EN != 0) begin : g_rep
            localparam logic [RW-1:0] RDLY_M1 = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] RPER_M1 = RW'(REPEAT_PERIOD - 1);

            logic [1:0]    state_q;
            logic [RW-1:0] rcnt_q;

            // a release on the same edge wins over a due repeat
            assign rep_set = !fall_set &&
                             (((state_q == ST_WAIT) && (rcnt_q == RDLY_M1)) ||
                              ((state_q == ST_REP)  && (rcnt_q == RPER_M1)));

            always_ff @(posedge Clk or negedge RstN) begin
                if (!RstN) begin
                    state_q <= ST_IDLE;
                    rcnt_q  <= '0;
                end else if (fall_set) begin
                    state_q <= ST_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            rcnt_q <= '0;
                            if (rise_set) state_q <= ST_WAIT;
                        end
                        ST_WAIT: begin
                            if (rcnt_q == RDLY_M1) begin
                                state_q <= ST_REP;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RW'(1);
                            end
                        end
                        ST_REP: begin
                            if (rcnt_q == RPER_M1) rcnt_q <= '0;
                            else                   rcnt_q <= rcnt_q + RW'(1);
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_norep
            assign rep_set = 1'b0;
        end

        assign DataClean[ch] = clean_q;
        assign Rise[ch]      = rise_q;
        assign Fall[ch]      = fall_q;
        assign Repeat[ch]    = rep_q;
        assign KeyEvent[ch]  = key_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed stimulus for debounce_multi; expected pulses/level edges queued by stimulus, matched by a negedge monitor.
module tb_debounce_multi;

    localparam int NCH = 4;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_REP  = 2;
    localparam int K_KEY  = 3;
    localparam int K_UP   = 4;
    localparam int K_DN   = 5;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic           Clk;
    logic           RstN;
    logic [NCH-1:0] DataNoisy;
    logic [NCH-1:0] DataClean;
    logic [NCH-1:0] Rise;
    logic [NCH-1:0] Fall;
    logic [NCH-1:0] Repeat;
    logic [NCH-1:0] KeyEvent;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];
    logic [NCH-1:0] prev_clean = '0;
    string kname[6] = '{"rise", "fall", "repeat", "keyevent", "clean_up", "clean_down"};

    debounce_multi #(
        .NCH(NCH), .NDELAY(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .Clk(Clk), .RstN(RstN), .DataNoisy(DataNoisy), .DataClean(DataClean),
        .Rise(Rise), .Fall(Fall), .Repeat(Repeat), .KeyEvent(KeyEvent)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc = c; e.ch = ch; e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic expect_press(input int ch, input int c);
        push_ev(c, ch, K_UP); push_ev(c, ch, K_RISE); push_ev(c, ch, K_KEY);
    endtask

    task automatic expect_rep(input int ch, input int c);
        push_ev(c, ch, K_REP); push_ev(c, ch, K_KEY);
    endtask

    task automatic expect_rel(input int ch, input int c);
        push_ev(c, ch, K_DN); push_ev(c, ch, K_FALL);
    endtask

    // an observed event must be waiting in the queue for this very cycle
    task automatic match(input int ch, input int kind);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].ch == ch && exp_q[i].kind == kind)
                idx = i;
        tests++;
        if (idx >= 0) begin
            exp_q.delete(idx);
        end else begin
            fails++;
            $display("FAIL unexpected %s ch%0d at cycle %0d: got pulse, required none", kname[kind], ch, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (!RstN) begin
            prev_clean = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (Rise[c])     match(c, K_RISE);
                if (Fall[c])     match(c, K_FALL);
                if (Repeat[c])   match(c, K_REP);
                if (KeyEvent[c]) match(c, K_KEY);
                if (DataClean[c] && !prev_clean[c]) match(c, K_UP);
                if (!DataClean[c] && prev_clean[c]) match(c, K_DN);
            end
            prev_clean = DataClean;
        end
    end

    task automatic check_zero(input string name);
        logic [5*NCH-1:0] got;
        got = {DataClean, Rise, Fall, Repeat, KeyEvent};
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL %s: outputs=%h required 0", name, got);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge Clk);
            #1;
        end
    endtask

    int e0;
    int e5;
    int e6;

    initial begin
        RstN      = 1'b0;
        DataNoisy = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset_hold");
        #2 RstN = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check_zero("reset_release");

        // clean step on ch0, held long enough for auto-repeat, release coincides with a due repeat
        e0 = cyc + 2;
        goto(e0);
        DataNoisy[0] = 1'b1;
        expect_press(0, e0 + 8);
        for (int k = 0; k < 7; k++) expect_rep(0, e0 + 18 + 3 * k);
        expect_rel(0, e0 + 39);

        goto(e0 + 2);  DataNoisy[1] = 1'b1;
        goto(e0 + 5);  DataNoisy[1] = 1'b0;

        // bounce on ch2; its release lands on the first-repeat cycle
        goto(e0 + 8);  DataNoisy[2] = 1'b1;
        expect_press(2, e0 + 20);
        expect_rel(2, e0 + 30);
        goto(e0 + 9);  DataNoisy[2] = 1'b0;
        goto(e0 + 10); DataNoisy[2] = 1'b1;
        goto(e0 + 11); DataNoisy[2] = 1'b0;
        goto(e0 + 12); DataNoisy[2] = 1'b1;

        goto(e0 + 16);
        check_bit("glitch_level_ch1", DataClean[1], 1'b0);
        check_bit("step_level_ch0", DataClean[0], 1'b1);
        check_bit("bounce_not_yet_ch2", DataClean[2], 1'b0);

        goto(e0 + 22); DataNoisy[2] = 1'b0;
        goto(e0 + 31); DataNoisy[0] = 1'b0;

        // re-press restarts the first-repeat delay
        goto(e0 + 45); DataNoisy[0] = 1'b1;
        expect_press(0, e0 + 53);
        expect_rep(0, e0 + 63);
        expect_rep(0, e0 + 66);
        expect_rel(0, e0 + 68);
        goto(e0 + 60); DataNoisy[0] = 1'b0;

        // async reset while ch0 is high and ch3 is mid-count
        e5 = e0 + 80;
        goto(e5);      DataNoisy[0] = 1'b1;
        expect_press(0, e5 + 8);
        goto(e5 + 10); DataNoisy[3] = 1'b1;
        goto(e5 + 14);
        check_bit("pre_reset_level_ch0", DataClean[0], 1'b1);
        #2 RstN = 1'b0;
        #1;
        check_zero("async_reset_immediate");
        DataNoisy = '0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check_zero("async_reset_hold");
        @(posedge Clk);
        #3 RstN = 1'b1;

        // simultaneous press on ch0 and ch3
        e6 = cyc + 3;
        goto(e6);
        DataNoisy[0] = 1'b1;
        DataNoisy[3] = 1'b1;
        expect_press(0, e6 + 8);
        expect_press(3, e6 + 8);
        expect_rep(0, e6 + 18);
        expect_rep(3, e6 + 18);
        expect_rel(0, e6 + 20);
        expect_rel(3, e6 + 20);
        goto(e6 + 4);
        check_zero("post_reset_quiet");
        goto(e6 + 12);
        DataNoisy[0] = 1'b0;
        DataNoisy[3] = 1'b0;
        goto(e6 + 30);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing %s ch%0d at cycle %0d: got none, required pulse", kname[e.kind], e.ch, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
